// File: rtl/uart_gain_rx.sv
// uart_gain_rx: 8N1 UART receiver (LSB first, idle high) plus a command-frame
// parser. A host uses it to retune the wall-follower PID gains (k_p, k_i, k_d)
// and the distance setpoint at run time.
// Frame: 0xA5, ADDR, DATA_HI, DATA_LO, CHK where CHK = ADDR ^ DATA_HI ^ DATA_LO.
// ADDR: 0=k_p, 1=k_i, 2=k_d, 3=setpoint (setpoint takes DATA_LO only).
// Build option: define FRAME_TIMEOUT_EN to add an inter-byte watchdog. The
// watchdog abandons a stalled partial frame after TIMEOUT_CLKS and pulses cmd_err.
module uart_gain_rx #(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned GAIN_WIDTH   = 16,
   parameter int unsigned SP_WIDTH     = 7,
   parameter int unsigned KP_RESET     = 582,
   parameter int unsigned KI_RESET     = 0,
   parameter int unsigned KD_RESET     = 74,
   parameter int unsigned SP_RESET     = 18,
   parameter int unsigned TIMEOUT_CLKS = 4 * 10 * CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  serial_rx,
   output logic [GAIN_WIDTH-1:0] k_p,
   output logic [GAIN_WIDTH-1:0] k_i,
   output logic [GAIN_WIDTH-1:0] k_d,
   output logic [SP_WIDTH-1:0]   setpoint,
   output logic                  upd_valid,
   output logic [1:0]            upd_addr,
   output logic                  frame_err,
   output logic                  cmd_err,
   output logic [7:0]            err_count
);

   localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_SYNC, P_ADDR, P_HI, P_LO, P_CHK} p_state_t;

   // Synchronizer and receiver
   logic             r_sync1;
   logic             r_sync2;
   logic             w_rx;
   rx_state_t        r_rx_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_rx_shift;
   logic [7:0]       r_byte;
   logic             r_byte_valid;
   logic             r_stop_low;

   // Parser and register file
   p_state_t             r_p_state;
   logic [1:0]           r_addr;
   logic [7:0]           r_hi;
   logic [7:0]           r_lo;
   logic [GAIN_WIDTH-1:0] r_k_p;
   logic [GAIN_WIDTH-1:0] r_k_i;
   logic [GAIN_WIDTH-1:0] r_k_d;
   logic [SP_WIDTH-1:0]  r_setpoint;
   logic                 r_upd_valid;
   logic [1:0]           r_upd_addr;
   logic                 r_frame_err;
   logic                 r_cmd_err;
   logic [7:0]           r_err_count;
   logic                 w_timeout;

   // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         // NOTE: non-blocking so r_sync2 takes the pre-edge r_sync1, giving two real flops.
         r_sync1 <= serial_rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx = r_sync2;

   // Bit-level receiver: find the start bit, sample mid-bit, shift in LSB first, check the stop bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_state   <= RX_IDLE;
         r_clk_cnt    <= '0;
         r_bit_idx    <= '0;
         r_rx_shift   <= '0;
         r_byte       <= '0;
         r_byte_valid <= 1'b0;
         r_stop_low   <= 1'b0;
      end else begin
         // NOTE: pulse flops default low every clock, so each assertion lasts exactly one cycle.
         r_byte_valid <= 1'b0;
         r_stop_low   <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_clk_cnt <= '0;
               r_bit_idx <= '0;
               if (!w_rx) r_rx_state <= RX_START;
            end
            RX_START: begin
               if (r_clk_cnt == CNT_HALF) begin
                  r_clk_cnt  <= '0;
                  // A line that is high again at mid-start-bit was only a glitch.
                  r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (r_clk_cnt == CNT_LAST) begin
                  r_clk_cnt  <= '0;
                  r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                  else                   r_bit_idx  <= r_bit_idx + 3'd1;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (r_clk_cnt == CNT_LAST) begin
                  r_clk_cnt  <= '0;
                  r_rx_state <= RX_IDLE;
                  if (w_rx) begin
                     r_byte       <= r_rx_shift;
                     r_byte_valid <= 1'b1;
                  end else begin
                     r_stop_low   <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // Frame parser: assemble A5-framed commands, write the addressed register, flag errors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p_state   <= P_SYNC;
         r_addr      <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_k_p       <= GAIN_WIDTH'(KP_RESET);
         r_k_i       <= GAIN_WIDTH'(KI_RESET);
         r_k_d       <= GAIN_WIDTH'(KD_RESET);
         r_setpoint  <= SP_WIDTH'(SP_RESET);
         r_upd_valid <= 1'b0;
         r_upd_addr  <= '0;
         r_frame_err <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_upd_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_cmd_err   <= 1'b0;
         // Only one of these events can occur per clock, so frame_err and cmd_err never overlap.
         if (r_stop_low) begin
            r_frame_err <= 1'b1;
            r_p_state   <= P_SYNC;
         end else if (r_byte_valid) begin
            case (r_p_state)
               P_SYNC: begin
                  if (r_byte == SYNC_BYTE) r_p_state <= P_ADDR;
               end
               P_ADDR: begin
                  if (r_byte > 8'd3) begin
                     r_cmd_err <= 1'b1;
                     r_p_state <= P_SYNC;
                  end else begin
                     r_addr    <= r_byte[1:0];
                     r_p_state <= P_HI;
                  end
               end
               P_HI: begin
                  r_hi      <= r_byte;
                  r_p_state <= P_LO;
               end
               P_LO: begin
                  r_lo      <= r_byte;
                  r_p_state <= P_CHK;
               end
               P_CHK: begin
                  r_p_state <= P_SYNC;
                  if (r_byte == ({6'd0, r_addr} ^ r_hi ^ r_lo)) begin
                     r_upd_valid <= 1'b1;
                     r_upd_addr  <= r_addr;
                     case (r_addr)
                        2'd0:    r_k_p      <= GAIN_WIDTH'({r_hi, r_lo});
                        2'd1:    r_k_i      <= GAIN_WIDTH'({r_hi, r_lo});
                        2'd2:    r_k_d      <= GAIN_WIDTH'({r_hi, r_lo});
                        default: r_setpoint <= SP_WIDTH'(r_lo);
                     endcase
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
               default: r_p_state <= P_SYNC;
            endcase
         end else if (w_timeout) begin
            r_cmd_err <= 1'b1;
            r_p_state <= P_SYNC;
         end
      end
   end

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TO_W-1:0] r_to_cnt;

   // Inter-byte watchdog: counts idle clocks inside a frame, restarts on every received byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt <= '0;
      end else if (r_byte_valid || r_stop_low || (r_p_state == P_SYNC) || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CLKS));
`else
   // No watchdog: a partial frame waits indefinitely. The term references
   // TIMEOUT_CLKS so both builds share one parameter list; it is constant low.
   assign w_timeout = (TIMEOUT_CLKS == 0) && 1'b0;
`endif

   // Saturating error counter, stepped once per frame_err or cmd_err pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_count <= '0;
      end else if ((r_frame_err || r_cmd_err) && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign k_p       = r_k_p;
   assign k_i       = r_k_i;
   assign k_d       = r_k_d;
   assign setpoint  = r_setpoint;
   assign upd_valid = r_upd_valid;
   assign upd_addr  = r_upd_addr;
   assign frame_err = r_frame_err;
   assign cmd_err   = r_cmd_err;
   assign err_count = r_err_count;

endmodule
